// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for the RV32I subset datapath.
// Sequences each instruction through FETCH/DECODE and the per-class execute
// states. It drives ALU control, mux selects and write enables, and it consumes
// the ALU Zero flag and the memory ready handshake.
module multicycle_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [2:0]  ALUctrl,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        instr_done,
    output logic        trap
);

    // Opcodes of the supported instruction classes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation encodings understood by the shared ALU
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_XOR   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;
    localparam logic [2:0] ALU_BNE   = 3'b101;
    localparam logic [2:0] ALU_BEQ   = 3'b111;

    // Mux select encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Immediate format encodings
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unusedInstrBits;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    // Register numbers and immediate bits belong to the datapath, not to control.
    assign unusedInstrBits = ^{instr[31], instr[29:15], instr[11:7]};

    // State register; reset returns to FETCH and abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs, with every enable forced low while reset is held
    always_comb begin
        state_d    = state_q;
        ALUctrl    = ALU_ADD;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;

        case (state_q)
            FETCH: begin
                AdrSrc    = 1'b0;
                MemRead   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ALUctrl   = ALU_ADD;
                ResultSrc = RES_ALURES;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                // The branch/jump target is computed speculatively into ALUOut here
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUctrl = ALU_ADD;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE, OP_LUI:  state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = TRAP;
                endcase
            end

            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUctrl = ALU_ADD;
                ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                if (funct3 != 3'b010) begin
                    state_d = TRAP;
                end else if (opcode == OP_STORE) begin
                    state_d = MEMWRITE;
                end else begin
                    state_d = MEMREAD;
                end
            end

            MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemRead   = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end

            MEMWRITE: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemWrite  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end

            MEMWB: begin
                ResultSrc  = RES_RDATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                case (funct3)
                    3'b000: begin
                        ALUctrl = funct7b5 ? ALU_SUB : ALU_ADD;
                        state_d = ALUWB;
                    end
                    3'b100: begin
                        ALUctrl = ALU_XOR;
                        state_d = ALUWB;
                    end
                    3'b111: begin
                        ALUctrl = ALU_AND;
                        state_d = ALUWB;
                    end
                    default: state_d = TRAP;
                endcase
            end

            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_LUI) begin
                    ImmSrc  = IMM_U;
                    ALUctrl = ALU_PASSB;
                    state_d = ALUWB;
                end else begin
                    ImmSrc = IMM_I;
                    case (funct3)
                        3'b000: begin
                            ALUctrl = ALU_ADD;
                            state_d = ALUWB;
                        end
                        3'b100: begin
                            ALUctrl = ALU_XOR;
                            state_d = ALUWB;
                        end
                        3'b111: begin
                            ALUctrl = ALU_AND;
                            state_d = ALUWB;
                        end
                        default: state_d = TRAP;
                    endcase
                end
            end

            ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            BRANCH: begin
                // ALUOut still holds the target from DECODE; the compare decides whether to take it
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                ResultSrc = RES_ALUOUT;
                case (funct3)
                    3'b000: begin
                        ALUctrl    = ALU_BEQ;
                        PCWrite    = ~Zero;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                    3'b001: begin
                        ALUctrl    = ALU_BNE;
                        PCWrite    = ~Zero;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                    default: state_d = TRAP;
                endcase
            end

            JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link value OldPC+4
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ALUctrl   = ALU_ADD;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                state_d   = ALUWB;
            end

            TRAP: begin
                trap    = 1'b1;
                state_d = TRAP;
            end

            default: state_d = FETCH;
        endcase

        if (rst) begin
            ALUctrl    = ALU_ADD;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
            trap       = 1'b0;
        end
    end

endmodule
